// File: rtl/stimulus_pulse_gen.sv
// Programmable burst pulse generator with start/busy/done handshake.
// Define PULSE_ECHO_CHECK_EN to enable the capture-path echo check.
module stimulus_pulse_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [NUM_W-1:0] num_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic [NUM_W-1:0] pulses_sent_o,
  output logic             echo_clr_o,
  input  logic             echo_i,
  output logic [NUM_W-1:0] echo_miss_o
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] sent_q, sent_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ok;

`ifdef PULSE_ECHO_CHECK_EN
  logic             echo_clr_q, echo_clr_d;
  logic [NUM_W-1:0] miss_q, miss_d;

  // One extra LOW cycle is needed so the echo can be sampled before the clear.
  assign cfg_ok = (width_i != '0) && (period_i > width_i) && (num_i != '0) &&
                  ((period_i - width_i) >= CNT_W'(2));
`else
  assign cfg_ok = (width_i != '0) && (period_i > width_i) && (num_i != '0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    period_d  = period_q;
    num_d     = num_q;
    sent_d    = sent_q;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
`ifdef PULSE_ECHO_CHECK_EN
    miss_d    = miss_q;
`endif

    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cfg_ok) begin
            width_d  = width_i;
            period_d = period_i;
            num_d    = num_i;
            sent_d   = '0;
`ifdef PULSE_ECHO_CHECK_EN
            miss_d   = '0;
`endif
            cnt_d    = width_i - 1'b1;
            pulse_d  = 1'b1;
            busy_d   = 1'b1;
            state_d  = StHigh;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StHigh: begin
        if (cnt_q == '0) begin
          cnt_d   = period_q - width_q - 1'b1;
          pulse_d = 1'b0;
          sent_d  = sent_q + 1'b1;
          state_d = StLow;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLow: begin
`ifdef PULSE_ECHO_CHECK_EN
        if (cnt_q == CNT_W'(1) && !echo_i) begin
          miss_d = miss_q + 1'b1;
        end
`endif
        if (cnt_q == '0) begin
          if (sent_q < num_q) begin
            cnt_d   = width_q - 1'b1;
            pulse_d = 1'b1;
            state_d = StHigh;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides every transition; the sent count is kept for inspection.
    if (abort_i && state_q != StIdle) begin
      state_d = StIdle;
      pulse_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      sent_d  = sent_q;
`ifdef PULSE_ECHO_CHECK_EN
      miss_d  = miss_q;
`endif
    end

`ifdef PULSE_ECHO_CHECK_EN
    echo_clr_d = (state_d == StIdle) || (state_d == StDone) ||
                 ((state_d == StLow) && (cnt_d == '0));
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      width_q    <= '0;
      period_q   <= '0;
      num_q      <= '0;
      sent_q     <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef PULSE_ECHO_CHECK_EN
      echo_clr_q <= 1'b1;
      miss_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      period_q   <= period_d;
      num_q      <= num_d;
      sent_q     <= sent_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
`ifdef PULSE_ECHO_CHECK_EN
      echo_clr_q <= echo_clr_d;
      miss_q     <= miss_d;
`endif
    end
  end

  assign pulse_o       = pulse_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;
  assign pulses_sent_o = sent_q;

`ifdef PULSE_ECHO_CHECK_EN
  assign echo_clr_o  = echo_clr_q;
  assign echo_miss_o = miss_q;
`else
  logic unused_echo;
  assign unused_echo = echo_i;
  assign echo_clr_o  = 1'b0;
  assign echo_miss_o = '0;
`endif

endmodule
